// File: rtl/cfg_pack_if.sv
// Handshake bundle for the field-to-word packer: a narrow field stream in
// (t_0_*), a packed word out (i_0_*), and the framing-error pulse.
interface cfg_pack_if #(
  parameter int FIELDS = 4,
  parameter int FW     = 8
);
  logic [FW-1:0]        t_0_dat;
  logic                 t_0_valid;
  logic                 t_0_last;
  logic                 t_0_ready;
  logic [FIELDS*FW-1:0] i_0_dat;
  logic                 i_0_valid;
  logic                 i_0_ready;
  logic                 err_0;

  // Packer side: consumes fields, produces words.
  modport slave (
    input  t_0_dat, t_0_valid, t_0_last, i_0_ready,
    output t_0_ready, i_0_dat, i_0_valid, err_0
  );

  // Environment side: produces fields, consumes words.
  modport master (
    output t_0_dat, t_0_valid, t_0_last, i_0_ready,
    input  t_0_ready, i_0_dat, i_0_valid, err_0
  );
endinterface

// File: rtl/cfg_pack.sv
// Field-to-word packer. Collects FIELDS narrow fields into one wide word with
// field 0 in the most-significant slot. A single hold register absorbs one
// completed word while the output register is still occupied.
module cfg_pack #(
  parameter int FIELDS = 4,
  parameter int FW     = 8
) (
  input  logic        clk,
  input  logic        reset,
  cfg_pack_if.slave   bus
);
  localparam int CW = $clog2(FIELDS);
  localparam int WW = FIELDS * FW;
  localparam int SW = (FIELDS - 1) * FW;
  localparam logic [CW-1:0] LAST_IDX = CW'(FIELDS - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] shadow;
  logic [WW-1:0] hold;
  logic          accept;
  logic          final_beat;
  logic          slot_free;
  logic          load_out;
  logic [WW-1:0] word;

  assign accept     = bus.t_0_valid & bus.t_0_ready;
  assign final_beat = accept & (cnt == LAST_IDX);
  assign slot_free  = !bus.i_0_valid | bus.i_0_ready;
  assign word       = {shadow, bus.t_0_dat};
  // The ready input is low in HOLD, so a final beat can only occur in COLLECT.
  assign load_out   = slot_free & (final_beat | (state == HOLD));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  // Next state: park in HOLD when a word completes with the output occupied.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (final_beat && !slot_free) state_nxt = HOLD;
      HOLD:    if (slot_free)                state_nxt = COLLECT;
      default:                               state_nxt = COLLECT;
    endcase
  end

  // Ready depends only on state and reset, never on the incoming valid.
  always_comb begin
    bus.t_0_ready = 1'b0;
    if (!reset && state == COLLECT) bus.t_0_ready = 1'b1;
  end

  // Field counter and shadow slots; a last beat before the final slot drops the partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (accept) begin
      if (final_beat || bus.t_0_last) begin
        cnt <= '0;
      end else begin
        shadow[(FIELDS - 2 - int'(cnt)) * FW +: FW] <= bus.t_0_dat;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Hold register captures a completed word that cannot enter the output yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   hold <= '0;
    else if (final_beat && !slot_free)           hold <= word;
  end

  // Output register: load on completion or hold drain, clear on consumption.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.i_0_dat   <= '0;
      bus.i_0_valid <= 1'b0;
    end else if (load_out) begin
      bus.i_0_valid <= 1'b1;
      bus.i_0_dat   <= (state == HOLD) ? hold : word;
    end else if (bus.i_0_ready) begin
      bus.i_0_valid <= 1'b0;
    end
  end

  // Framing error: last flag disagrees with the slot position of the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.err_0 <= 1'b0;
    else       bus.err_0 <= accept & (bus.t_0_last ^ (cnt == LAST_IDX));
  end
endmodule

// File: doc/cfg_pack.md
# cfg_pack

Field-to-word packer for the configuration datapath, the inverse of the config field splitter. Accepts a stream of `FIELDS` narrow configuration fields over a valid/ready handshake and assembles them into one `FIELDS*FW`-bit word. Field 0 lands in the most-significant slot, so the packed word feeds a field splitter unchanged. Sits between the serial config source and the wide config consumer, with single-word skid buffering for back-pressure.

## Interface
- `FIELDS`, 4, number of fields per word; legal range 2..16.
- `FW`, 8, width of each field in bits; the packed word is `FIELDS*FW` bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `t_0_dat`  in  `[FW-1:0]`  incoming field.
- `t_0_valid`  in  1  incoming field valid.
- `t_0_last`  in  1  marks the final field of a frame; qualified by `t_0_valid`.
- `t_0_ready`  out  1  packer accepts a field; a beat transfers when `t_0_valid & t_0_ready`.
- `i_0_dat`  out  `[FIELDS*FW-1:0]`  packed word; field k occupies `[(FIELDS-k)*FW-1 : (FIELDS-1-k)*FW]`.
- `i_0_valid`  out  1  packed word valid.
- `i_0_ready`  in  1  downstream accepts; a word transfers when `i_0_valid & i_0_ready`.
- `err_0`  out  1  one-cycle pulse on a framing error.

## Operation
- Internal state:
  - field counter `cnt`, `$clog2(FIELDS)` bits;
  - shadow register of `(FIELDS-1)*FW` bits for fields 0..FIELDS-2;
  - hold register of `FIELDS*FW` bits;
  - output register (`i_0_dat`/`i_0_valid`);
  - FSM with states COLLECT and HOLD.
- Slot free: `slot_free = !i_0_valid | i_0_ready`.
- COLLECT:
  - `t_0_ready = 1`.
  - Accepted beat with `cnt < FIELDS-1`:
    - `t_0_last = 0`: write `t_0_dat` into shadow slot `cnt` and increment `cnt`.
    - `t_0_last = 1` (short frame): discard the partial word, set `cnt` to 0, pulse `err_0`. Nothing is emitted.
  - Accepted beat with `cnt == FIELDS-1` (final beat): `cnt` goes to 0 and the word is `{shadow, t_0_dat}`.
    - If `slot_free`: load the word into the output register and set `i_0_valid`.
    - Otherwise: load the word into the hold register and go to HOLD.
    - If `t_0_last = 0` on the final beat (long frame): the word is still committed and `err_0` pulses. The next beat starts a new word at `cnt = 0`.
- HOLD:
  - `t_0_ready = 0`.
  - When `slot_free`: move the hold register to the output register, set `i_0_valid`, and return to COLLECT.
- Output register:
  - When `i_0_valid & i_0_ready` and no new word is loaded that cycle, `i_0_valid` clears.
  - `i_0_dat` holds its last value when not valid.
  - `i_0_dat` and `i_0_valid` must not change while `i_0_valid & !i_0_ready`.
- Width rules:
  - Fields are never truncated or extended.
  - `cnt` saturates only via the final-beat reset; it never wraps by overflow.

## Timing
- Reset values while `reset` is high, and after release until the first edge:
  - `i_0_valid = 0`, `i_0_dat = 0`, `err_0 = 0`;
  - `cnt = 0`, shadow and hold registers 0, FSM in COLLECT;
  - `t_0_ready = 0` (gated by `reset`), becoming 1 in the first cycle after release.
- Reset asserted mid-frame or in HOLD discards all partial and held data immediately, asynchronously.
- Latency: a final beat accepted at edge k with the slot free gives `i_0_valid = 1` and the packed word in the cycle after edge k.
- Throughput: one field per cycle sustained while `i_0_ready = 1`; one word per `FIELDS` cycles.
- Stalls:
  - A final beat with the slot occupied costs nothing at entry.
  - HOLD persists until the first cycle with `slot_free`; the word moves at that edge and `t_0_ready` returns to 1 in the next cycle.
- Simultaneous events: downstream consumption and a final beat in the same cycle load the new word directly, so `i_0_valid` stays high with no bubble.
- `err_0` is registered and is high for exactly the cycle after the offending beat.
- `t_0_ready` is combinational from FSM state and `reset` only, never from `t_0_valid`.

## Test plan
- FIELDS=4, FW=8, `i_0_ready=1`. Send 0x11, 0x22, 0x33, 0x44 with `last` on 0x44 → one cycle later `i_0_valid=1`, `i_0_dat=0x11223344`, `err_0=0`.
- Back-to-back frames {0x01..0x04} and {0xA1..0xA4}, streaming at full rate → words 0x01020304 then 0xA1A2A3A4 on consecutive 4-cycle boundaries, `t_0_ready` never drops.
- Hold `i_0_ready=0` for two complete frames → first word held stable on `i_0_dat`; second frame's final beat is accepted, then `t_0_ready=0`. Raise `i_0_ready` → first word transfers, second appears the next cycle, then `t_0_ready=1`.
- Send 0xAA, 0xBB with `last` on 0xBB → `err_0` pulses one cycle, no `i_0_valid`; the following frame 0x01..0x04 yields 0x01020304.
- Send 0x10..0x13 with no `last` → word 0x10111213 emitted and `err_0` pulses with the output.
- Assert `reset` after two fields and again while in HOLD → `i_0_valid=0`, `t_0_ready=0` during reset; after release a fresh frame 0x55, 0x66, 0x77, 0x88 yields 0x55667788.
